// File: rtl/mem_io_responder.sv
// mem_io_responder
//   Memory-side responder for the CPU byte-wide memory bus. One byte per cycle
//   is served from an internal byte RAM. The IO page (cpu_a[17:16] == 2'b11)
//   holds a UART TX FIFO, a UART RX FIFO and a simulation-halt register.
//
//   Handshakes: the CPU side is qualified only by rdy (no backpressure; the CPU
//   watches io_buffer_full before starting an IO store). The UART TX side
//   transfers a byte on any edge where tx_valid && tx_ready; the UART RX side
//   pushes on any edge where rx_valid is high. Both UART sides ignore rdy.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   rdy            global ready; 0 freezes all CPU-side actions
//   cpu_a          byte address (only [17:0] decoded)
//   cpu_wr         write strobe
//   cpu_dout       write data from CPU
//   cpu_din        registered read data to CPU
//   io_buffer_full TX FIFO has two or fewer free slots
//   tx_data        TX FIFO head (0 when empty)
//   tx_valid       TX FIFO non-empty
//   tx_ready       UART accepts tx_data
//   rx_data        UART received byte
//   rx_valid       push rx_data into RX FIFO
//   sim_halt       sticky, set by a write to 0x30004
//   tx_overflow    sticky, set when a TX store is dropped on a full FIFO
module mem_io_responder #(
   parameter int RAM_AW     = 17,
   parameter int FIFO_DEPTH = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic [31:0] cpu_a,
   input  logic        cpu_wr,
   input  logic [7:0]  cpu_dout,
   output logic [7:0]  cpu_din,
   output logic        io_buffer_full,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        sim_halt,
   output logic        tx_overflow
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   logic [7:0]    ram [0:(2**RAM_AW)-1];
   logic [7:0]    tx_mem [0:FIFO_DEPTH-1];
   logic [7:0]    rx_mem [0:FIFO_DEPTH-1];

   logic [CW-1:0] tx_wptr, tx_rptr, rx_wptr, rx_rptr;
   logic [CW-1:0] tx_count, rx_count;
   logic [17:0]   addr, prev_addr;
   logic [15:0]   off;
   logic          io, addr_changed;
   logic          tx_full, rx_full, rx_empty;
   logic          tx_push_req, tx_push, tx_pop, tx_drop;
   logic          rx_push, rx_pop;
   logic          halt_wr, ram_wr;
   logic          unused_addr_bits;

   assign unused_addr_bits = ^cpu_a[31:18];

   assign addr         = cpu_a[17:0];
   assign off          = addr[15:0];
   assign io           = (addr[17:16] == 2'b11);
   // RXD pops only on the first cycle an address is presented, so a CPU that
   // holds the read address for several cycles consumes a single byte.
   assign addr_changed = (addr != prev_addr);

   assign tx_count = tx_wptr - tx_rptr;
   assign rx_count = rx_wptr - rx_rptr;
   assign tx_full  = (tx_count == CW'(FIFO_DEPTH));
   assign rx_full  = (rx_count == CW'(FIFO_DEPTH));
   assign rx_empty = (rx_count == '0);

   assign tx_valid       = (tx_count != '0);
   assign tx_data        = tx_valid ? tx_mem[tx_rptr[PW-1:0]] : 8'h00;
   // Two slots of headroom: the CPU issues its store one cycle after checking.
   assign io_buffer_full = (tx_count >= CW'(FIFO_DEPTH - 2));

   assign ram_wr      = rdy && cpu_wr && !io;
   assign halt_wr     = rdy && cpu_wr && io && (off == 16'h0004);
   assign tx_push_req = rdy && cpu_wr && io && (off == 16'h0000);
   assign tx_pop      = tx_valid && tx_ready;
   // A pop in the same edge frees the slot the push needs, even when full.
   assign tx_push     = tx_push_req && (!tx_full || tx_pop);
   assign tx_drop     = tx_push_req && tx_full && !tx_pop;

   assign rx_pop  = rdy && !cpu_wr && io && (off == 16'h0000) && addr_changed && !rx_empty;
   assign rx_push = rx_valid && (!rx_full || rx_pop);

   // Storage arrays carry no reset; RAM contents survive rst.
   always_ff @(posedge clk) begin
      if (ram_wr) ram[cpu_a[RAM_AW-1:0]] <= cpu_dout;
      if (tx_push && !rst) tx_mem[tx_wptr[PW-1:0]] <= cpu_dout;
      if (rx_push && !rst) rx_mem[rx_wptr[PW-1:0]] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_wptr     <= '0;
         tx_rptr     <= '0;
         rx_wptr     <= '0;
         rx_rptr     <= '0;
         prev_addr   <= '0;
         sim_halt    <= 1'b0;
         tx_overflow <= 1'b0;
      end else begin
         if (tx_push) tx_wptr <= tx_wptr + 1'b1;
         if (tx_pop)  tx_rptr <= tx_rptr + 1'b1;
         if (rx_push) rx_wptr <= rx_wptr + 1'b1;
         if (rx_pop)  rx_rptr <= rx_rptr + 1'b1;
         if (rdy)     prev_addr <= addr;
         if (halt_wr) sim_halt <= 1'b1;
         if (tx_drop) tx_overflow <= 1'b1;
      end
   end

   // Read data: RAM reads see the pre-write byte (read-before-write); write
   // cycles and rdy=0 cycles leave cpu_din untouched.
   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_din <= 8'h00;
      end else if (rdy && !cpu_wr) begin
         if (!io) begin
            cpu_din <= ram[cpu_a[RAM_AW-1:0]];
         end else if (off == 16'h0000) begin
            if (addr_changed) cpu_din <= rx_empty ? 8'h00 : rx_mem[rx_rptr[PW-1:0]];
         end else if (off == 16'h0004) begin
            cpu_din <= {6'b0, !rx_empty, tx_full};
         end else begin
            cpu_din <= 8'h00;
         end
      end
   end

endmodule

// File: tb/tb_mem_io_responder.sv
// tb_mem_io_responder
//   Directed bench for mem_io_responder. Read results and TX bytes are tracked
//   in expected queues; every comparison goes through chk().
module tb_mem_io_responder;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic [31:0] cpu_a;
   logic        cpu_wr;
   logic [7:0]  cpu_dout;
   logic [7:0]  cpu_din;
   logic        io_buffer_full;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        sim_halt;
   logic        tx_overflow;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] tx_q[$];
   logic [7:0] rd_q[$];

   localparam logic [31:0] TXD  = 32'h0003_0000;
   localparam logic [31:0] STAT = 32'h0003_0004;

   mem_io_responder #(.RAM_AW(17), .FIFO_DEPTH(8)) dut (
      .clk            (clk),
      .rst            (rst),
      .rdy            (rdy),
      .cpu_a          (cpu_a),
      .cpu_wr         (cpu_wr),
      .cpu_dout       (cpu_dout),
      .cpu_din        (cpu_din),
      .io_buffer_full (io_buffer_full),
      .tx_data        (tx_data),
      .tx_valid       (tx_valid),
      .tx_ready       (tx_ready),
      .rx_data        (rx_data),
      .rx_valid       (rx_valid),
      .sim_halt       (sim_halt),
      .tx_overflow    (tx_overflow)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: TX handshakes happening at this edge are scored first, then
   // the bench resumes 1 time unit after the edge.
   task automatic tick();
      logic [7:0] e;
      #1;
      if (tx_valid && tx_ready) begin
         if (tx_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL tx_extra_pop: observed %0h expected no transfer", tx_data);
         end else begin
            e = tx_q.pop_front();
            chk("tx_data_drain", 32'(tx_data), 32'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_write(input logic [31:0] a, input logic [7:0] d);
      cpu_a    = a;
      cpu_dout = d;
      cpu_wr   = 1'b1;
      tick();
      cpu_wr   = 1'b0;
   endtask

   task automatic cpu_read(input logic [31:0] a, input logic [7:0] exp, input string tag);
      rd_q.push_back(exp);
      cpu_a  = a;
      cpu_wr = 1'b0;
      tick();
      chk(tag, 32'(cpu_din), 32'(rd_q.pop_front()));
   endtask

   task automatic rx_push(input logic [7:0] d);
      rx_data  = d;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1; cpu_a = '0; cpu_wr = 1'b0; cpu_dout = '0;
      tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // reset state
      chk("rst_cpu_din",     32'(cpu_din), 32'h0);
      chk("rst_tx_valid",    32'(tx_valid), 32'h0);
      chk("rst_tx_data",     32'(tx_data), 32'h0);
      chk("rst_buf_full",    32'(io_buffer_full), 32'h0);
      chk("rst_sim_halt",    32'(sim_halt), 32'h0);
      chk("rst_tx_overflow", 32'(tx_overflow), 32'h0);

      // preload RAM bytes used later
      cpu_write(32'h0000_0011, 8'h3C);
      cpu_write(32'h0000_0000, 8'h5A);
      cpu_write(32'h0000_0020, 8'h12);

      // 1: RAM write then read
      cpu_write(32'h0000_0010, 8'hA5);
      cpu_read(32'h0000_0010, 8'hA5, "ram_rd_10");
      cpu_read(32'h0000_0011, 8'h3C, "ram_rd_11");
      cpu_write(32'h0000_0010, 8'h55);
      chk("wr_holds_din", 32'(cpu_din), 32'h3C);
      cpu_read(32'h0000_0010, 8'h55, "ram_rd_10_new");

      // 2: fill TX with tx_ready low, ninth store overflows
      for (int i = 1; i <= 9; i++) begin
         if (i <= 8) tx_q.push_back(8'(8'h40 + i));
         cpu_write(TXD, 8'(8'h40 + i));
         chk($sformatf("buf_full_%0d", i), 32'(io_buffer_full), (i >= 6) ? 32'h1 : 32'h0);
         chk($sformatf("tx_ovf_%0d", i), 32'(tx_overflow), (i >= 9) ? 32'h1 : 32'h0);
      end
      chk("tx_head_first", 32'(tx_data), 32'h41);
      cpu_read(STAT, 8'h01, "stat_tx_full");

      // drain, order checked by tick()
      tx_ready = 1'b1;
      repeat (8) tick();
      tx_ready = 1'b0;
      chk("tx_empty_after_drain", 32'(tx_valid), 32'h0);

      // 3: RX pop edge detection
      rx_push(8'h11);
      rx_push(8'h22);
      cpu_read(TXD, 8'h11, "rx_pop1_c1");
      cpu_read(TXD, 8'h11, "rx_pop1_c2");
      cpu_read(TXD, 8'h11, "rx_pop1_c3");
      cpu_read(32'h0000_0000, 8'h5A, "ram_rd_0");
      cpu_read(TXD, 8'h22, "rx_pop2");
      cpu_read(32'h0000_0010, 8'h55, "ram_rd_10_again");
      cpu_read(TXD, 8'h00, "rx_empty_read");
      cpu_read(STAT, 8'h00, "stat_all_empty");

      // 5: halt register and reset
      cpu_write(STAT, 8'hFF);
      chk("sim_halt_set", 32'(sim_halt), 32'h1);
      tick();
      tick();
      chk("sim_halt_sticky", 32'(sim_halt), 32'h1);
      for (int i = 0; i < 6; i++) begin
         tx_q.push_back(8'(8'h60 + i));
         cpu_write(TXD, 8'(8'h60 + i));
      end
      chk("buf_full_pre_rst", 32'(io_buffer_full), 32'h1);
      rx_push(8'h33);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tx_q.delete();
      chk("rst2_sim_halt", 32'(sim_halt), 32'h0);
      chk("rst2_buf_full", 32'(io_buffer_full), 32'h0);
      chk("rst2_tx_valid", 32'(tx_valid), 32'h0);
      chk("rst2_cpu_din",  32'(cpu_din), 32'h0);
      cpu_read(STAT, 8'h00, "rst2_stat");

      // 4: push and pop on a full TX FIFO in one edge
      for (int i = 0; i < 8; i++) begin
         tx_q.push_back(8'(8'hC0 + i));
         cpu_write(TXD, 8'(8'hC0 + i));
      end
      chk("full_no_ovf", 32'(tx_overflow), 32'h0);
      tx_ready = 1'b1;
      tx_q.push_back(8'hCF);
      cpu_write(TXD, 8'hCF);
      tx_ready = 1'b0;
      chk("pushpop_no_ovf", 32'(tx_overflow), 32'h0);
      chk("pushpop_head", 32'(tx_data), 32'hC1);
      cpu_read(STAT, 8'h01, "pushpop_still_full");

      // 6: rdy low blocks RAM writes, TX still drains
      rdy      = 1'b0;
      cpu_a    = 32'h0000_0020;
      cpu_dout = 8'h77;
      cpu_wr   = 1'b1;
      tx_ready = 1'b1;
      repeat (8) tick();
      chk("rdy0_din_hold", 32'(cpu_din), 32'h01);
      chk("rdy0_tx_drained", 32'(tx_valid), 32'h0);
      cpu_wr   = 1'b0;
      tx_ready = 1'b0;
      rdy      = 1'b1;
      cpu_read(32'h0000_0020, 8'h12, "rdy0_ram_unchanged");
      chk("tx_q_consumed", 32'(tx_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
